// File: rtl/instr_buffer.sv
// Instruction fetch buffer: circular FIFO of {pc, instr, adel} between fetch and decode.
// Optional same-cycle fetch-to-decode bypass when empty is enabled by defining IBUF_BYPASS_EN.
module instr_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush_i,
  input  logic          if_valid_i,
  output logic          if_ready_o,
  input  logic [31:0]   if_pc_i,
  input  logic [31:0]   if_instr_i,
  input  logic          if_adel_i,
  input  logic          id_stall_i,
  output logic          id_valid_o,
  output logic [31:0]   id_pc_o,
  output logic [31:0]   id_instr_o,
  output logic          id_adel_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          adel_mem  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic full, empty, bypass, push, pop, pop_buf;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

`ifdef IBUF_BYPASS_EN
  assign bypass = empty & if_valid_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign if_ready_o = ~full;
  assign count_o    = count_q;
  assign id_valid_o = (~empty | bypass) & ~flush_i;

  assign pop     = id_valid_o & ~id_stall_i;
  // A bypassed entry consumed by decode never occupies a slot.
  assign pop_buf = pop & ~empty;
  assign push    = if_valid_i & if_ready_o & ~flush_i & ~(bypass & ~id_stall_i);

  always_comb begin
    id_pc_o    = '0;
    id_instr_o = '0;
    id_adel_o  = 1'b0;
    if (id_valid_o) begin
      if (bypass) begin
        id_pc_o    = if_pc_i;
        id_instr_o = if_instr_i;
        id_adel_o  = if_adel_i;
      end else begin
        id_pc_o    = pc_mem[rd_ptr_q];
        id_instr_o = instr_mem[rd_ptr_q];
        id_adel_o  = adel_mem[rd_ptr_q];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)    wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_buf) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop_buf})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; contents are only visible through a valid head.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= if_pc_i;
      instr_mem[wr_ptr_q] <= if_instr_i;
      adel_mem[wr_ptr_q]  <= if_adel_i;
    end
  end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer with a queue scoreboard of expected head entries.
module tb_instr_buffer;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush_i;
  logic          if_valid_i;
  logic          if_ready_o;
  logic [31:0]   if_pc_i;
  logic [31:0]   if_instr_i;
  logic          if_adel_i;
  logic          id_stall_i;
  logic          id_valid_o;
  logic [31:0]   id_pc_o;
  logic [31:0]   id_instr_o;
  logic          id_adel_o;
  logic [AW:0]   count_o;

  instr_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush_i    (flush_i),
    .if_valid_i (if_valid_i),
    .if_ready_o (if_ready_o),
    .if_pc_i    (if_pc_i),
    .if_instr_i (if_instr_i),
    .if_adel_i  (if_adel_i),
    .id_stall_i (id_stall_i),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_instr_o (id_instr_o),
    .id_adel_o  (id_adel_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } entry_t;

  entry_t model[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle against the model, advance.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic adel, input logic stall, input logic fl);
    int     cnt;
    logic   byp, exp_valid;
    entry_t head;
    if_valid_i = v;
    if_pc_i    = pc;
    if_instr_i = ins;
    if_adel_i  = adel;
    id_stall_i = stall;
    flush_i    = fl;
    #3;
    cnt       = model.size();
    byp       = BYP && (cnt == 0) && v && !fl;
    exp_valid = ((cnt != 0) || byp) && !fl;
    head      = (cnt != 0) ? model[0] : '{pc: pc, instr: ins, adel: adel};
    chk("if_ready", {31'b0, if_ready_o}, {31'b0, cnt < DEPTH});
    chk("count", 32'(count_o), 32'(cnt));
    chk("id_valid", {31'b0, id_valid_o}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("head_pc", id_pc_o, head.pc);
      chk("head_instr", id_instr_o, head.instr);
      chk("head_adel", {31'b0, id_adel_o}, {31'b0, head.adel});
    end else begin
      chk("idle_pc", id_pc_o, 32'h0);
      chk("idle_instr", id_instr_o, 32'h0);
      chk("idle_adel", {31'b0, id_adel_o}, 32'h0);
    end
    if (fl) begin
      model.delete();
    end else begin
      if (exp_valid && !stall && cnt != 0) void'(model.pop_front());
      if (v && cnt < DEPTH && !(byp && !stall))
        model.push_back('{pc: pc, instr: ins, adel: adel});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic stall);
    step(1'b0, 32'h0, 32'h0, 1'b0, stall, 1'b0);
  endtask

  initial begin
    resetn     = 1'b0;
    flush_i    = 1'b0;
    if_valid_i = 1'b0;
    if_pc_i    = '0;
    if_instr_i = '0;
    if_adel_i  = 1'b0;
    id_stall_i = 1'b0;
    #2;
    chk("rst_valid", {31'b0, id_valid_o}, 32'h0);
    chk("rst_count", 32'(count_o), 32'h0);
    chk("rst_ready", {31'b0, if_ready_o}, 32'h1);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset mid-stream with five entries queued
    for (int k = 0; k < 5; k++)
      step(1'b1, 32'h1000 + 32'(k) * 4, 32'hA000_0000 + 32'(k), 1'b0, 1'b1, 1'b0);
    if_valid_i = 1'b0;
    resetn     = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, id_valid_o}, 32'h0);
    chk("midrst_count", 32'(count_o), 32'h0);
    chk("midrst_ready", {31'b0, if_ready_o}, 32'h1);
    chk("midrst_instr", id_instr_o, 32'h0);
    model.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(1'b0);

    // Fill with decode stalled; ninth offer is refused
    for (int k = 0; k < 9; k++)
      step(1'b1, 32'hBFC0_0000 + 32'(k) * 4, 32'h2000_0000 + 32'(k), 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) idle(1'b0);
    idle(1'b0);

    // Sustained push/pop at occupancy 3 across pointer wrap
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h0040_0000 + 32'(k) * 4, 32'h3000_0000 + 32'(k), 1'b0, 1'b1, 1'b0);
    for (int k = 3; k < 23; k++)
      step(1'b1, 32'h0040_0000 + 32'(k) * 4, 32'h3000_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) idle(1'b0);

    // Flush at occupancy 6 together with an offered entry
    for (int k = 0; k < 6; k++)
      step(1'b1, 32'h0080_0000 + 32'(k) * 4, 32'h4000_0000 + 32'(k), 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0080_0100, 32'h2402_0001, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    step(1'b1, 32'h0080_0200, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Fetch exception flag travels with its entry
    step(1'b1, 32'h0000_0003, 32'h5555_0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0008, 32'h5555_0001, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

`ifdef IBUF_BYPASS_EN
    // Bypass: consumed same cycle, then stalled and written
    step(1'b1, 32'h0000_1000, 32'h3C01_1234, 1'b0, 1'b0, 1'b0);
    chk("byp_count0", 32'(count_o), 32'h0);
    step(1'b1, 32'h0000_1004, 32'h3C01_1234, 1'b0, 1'b1, 1'b0);
    chk("byp_count1", 32'(count_o), 32'h1);
    idle(1'b0);
    idle(1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
